// File: rtl/audio_pkg.sv
// audio_pkg: shared state encodings and PCM conversion helpers for the voice mixer.
package audio_pkg;

   // Per-voice envelope phases.
   typedef enum logic [1:0] {
      ENV_IDLE    = 2'd0,
      ENV_ATTACK  = 2'd1,
      ENV_SUSTAIN = 2'd2,
      ENV_RELEASE = 2'd3
   } env_state_e;

   // Mixer sequencing phases: wait for strobe, accumulate voices, emit result.
   typedef enum logic [1:0] {
      MIX_IDLE = 2'd0,
      MIX_ACC  = 2'd1,
      MIX_OUT  = 2'd2
   } mix_state_e;

   // Offset-binary midpoint 2**(dw-1), zero-extended to 64 bits.
   function automatic logic [63:0] PCM_MID(input int unsigned dw);
      PCM_MID = 64'd1 << (dw - 32'd1);
   endfunction

   // Offset-binary to two's complement: invert the MSB of a dw-bit code.
   function automatic logic [63:0] offset_to_signed(input logic [63:0] x, input int unsigned dw);
      offset_to_signed = x ^ PCM_MID(dw);
   endfunction

   // Two's complement to offset-binary: invert the MSB of a dw-bit value.
   function automatic logic [63:0] signed_to_offset(input logic [63:0] x, input int unsigned dw);
      signed_to_offset = x ^ PCM_MID(dw);
   endfunction

   // Clamp a signed value into the dw-bit two's complement range.
   function automatic logic signed [63:0] sat_signed(input logic signed [63:0] y, input int unsigned dw);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (dw - 32'd1)) - 64'sd1;
      lo = -(64'sd1 <<< (dw - 32'd1));
      if (y > hi) begin
         sat_signed = hi;
      end else if (y < lo) begin
         sat_signed = lo;
      end else begin
         sat_signed = y;
      end
   endfunction

endpackage

// File: rtl/voice_env.sv
// voice_env: attack/sustain/release envelope for one voice, stepped on a shared tick.
module voice_env
   import audio_pkg::*;
#(
   parameter int ENVW = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            tick_i,
   input  logic            gate_i,
   input  logic [ENVW-1:0] attack_step_i,
   input  logic [ENVW-1:0] release_step_i,
   output logic [ENVW-1:0] level_o,
   output logic            active_o
);

   localparam logic [ENVW-1:0] LVL_MAX  = {ENVW{1'b1}};
   localparam logic [ENVW-1:0] LVL_ZERO = {ENVW{1'b0}};

   env_state_e      state_q, state_d;
   logic [ENVW-1:0] level_q, level_d;
   logic            active_q;
   logic [ENVW:0]   attack_sum_s;

   // Next envelope state and level; gate changes win over the tick step.
   always_comb begin
      state_d      = state_q;
      level_d      = level_q;
      attack_sum_s = {1'b0, level_q} + {1'b0, attack_step_i};
      case (state_q)
         ENV_IDLE: begin
            if (gate_i) begin
               state_d = ENV_ATTACK;
            end else begin
               state_d = ENV_IDLE;
            end
         end
         ENV_ATTACK: begin
            if (!gate_i) begin
               state_d = ENV_RELEASE;
            end else if (attack_step_i == LVL_ZERO) begin
               level_d = LVL_MAX;
               state_d = ENV_SUSTAIN;
            end else if (tick_i) begin
               if (attack_sum_s[ENVW] || (attack_sum_s[ENVW-1:0] == LVL_MAX)) begin
                  level_d = LVL_MAX;
                  state_d = ENV_SUSTAIN;
               end else begin
                  level_d = attack_sum_s[ENVW-1:0];
               end
            end else begin
               level_d = level_q;
            end
         end
         ENV_SUSTAIN: begin
            level_d = LVL_MAX;
            if (!gate_i) begin
               state_d = ENV_RELEASE;
            end else begin
               state_d = ENV_SUSTAIN;
            end
         end
         ENV_RELEASE: begin
            if (gate_i) begin
               state_d = ENV_ATTACK;
            end else if (release_step_i == LVL_ZERO) begin
               level_d = LVL_ZERO;
               state_d = ENV_IDLE;
            end else if (tick_i) begin
               if (release_step_i >= level_q) begin
                  level_d = LVL_ZERO;
                  state_d = ENV_IDLE;
               end else begin
                  level_d = level_q - release_step_i;
               end
            end else begin
               level_d = level_q;
            end
         end
         default: begin
            state_d = ENV_IDLE;
            level_d = LVL_ZERO;
         end
      endcase
   end

   // Envelope registers; the active flag is registered alongside the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ENV_IDLE;
         level_q  <= LVL_ZERO;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         level_q  <= level_d;
         active_q <= (state_d != ENV_IDLE);
      end
   end

   assign level_o  = level_q;
   assign active_o = active_q;

endmodule

// File: rtl/voice_mixer.sv
// voice_mixer: time-multiplexed NCH-voice mixer with per-voice volume and envelope,
// one shared multiply-accumulate, saturating offset-binary output.
module voice_mixer
   import audio_pkg::*;
#(
   parameter int NCH     = 4,
   parameter int DW      = 16,
   parameter int VOLW    = 4,
   parameter int ENVW    = 8,
   parameter int ENV_DIV = 1024
) (
   input  logic [0:0]          clk,
   input  logic                rst_n,
   input  logic                sample_stb,
   input  logic [NCH*DW-1:0]   pcm_in,
   input  logic [NCH*VOLW-1:0] vol,
   input  logic [NCH-1:0]      gate,
   input  logic [ENVW-1:0]     attack_step,
   input  logic [ENVW-1:0]     release_step,
   output logic [DW-1:0]       pcm_out,
   output logic                out_valid,
   output logic                busy,
   output logic                overrun,
   output logic [NCH-1:0]      env_active
);

   localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int PW    = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;
   localparam int ACCW  = DW + VOLW + ENVW + $clog2(NCH) + 1;
   localparam int SHIFT = VOLW + ENVW;

   localparam logic [DW-1:0] PCM_MID_C  = DW'(PCM_MID(DW));
   localparam logic [CW-1:0] CH_LAST    = CW'(NCH - 1);
   localparam logic [PW-1:0] PRESC_LAST = PW'(ENV_DIV - 1);

   // Envelope prescaler
   logic [PW-1:0]          presc_q;
   logic                   tick_s;
   logic [NCH*ENVW-1:0]    lvl_s;

   // Mix sequencer and snapshot
   mix_state_e             mix_q, mix_d;
   logic [CW-1:0]          ch_q, ch_d;
   logic signed [ACCW-1:0] acc_q, acc_d;
   logic [NCH*DW-1:0]      pcm_snap_q, pcm_snap_d;
   logic [NCH*VOLW-1:0]    vol_snap_q, vol_snap_d;
   logic [NCH*ENVW-1:0]    lvl_snap_q, lvl_snap_d;
   logic [DW-1:0]          pcm_out_q, pcm_out_d;
   logic                   out_valid_q, out_valid_d;
   logic                   busy_q, busy_d;
   logic                   overrun_q, overrun_d;

   // Datapath
   logic [DW-1:0]          pcm_sel_s;
   logic [VOLW-1:0]        vol_sel_s;
   logic [ENVW-1:0]        lvl_sel_s;
   logic signed [DW-1:0]   samp_s;
   logic signed [ACCW-1:0] prod_s;
   logic signed [ACCW-1:0] shift_s;
   logic signed [DW-1:0]   clip_s;
   logic [DW-1:0]          out_code_s;

   assign tick_s = (presc_q == PRESC_LAST);

   // Free-running envelope prescaler producing a one-cycle tick every ENV_DIV clocks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= {PW{1'b0}};
      end else if (tick_s) begin
         presc_q <= {PW{1'b0}};
      end else begin
         presc_q <= presc_q + PW'(1);
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_voice
      voice_env #(
         .ENVW (ENVW)
      ) u_env (
         .clk            (clk),
         .rst_n          (rst_n),
         .tick_i         (tick_s),
         .gate_i         (gate[i]),
         .attack_step_i  (attack_step),
         .release_step_i (release_step),
         .level_o        (lvl_s[i*ENVW +: ENVW]),
         .active_o       (env_active[i])
      );
   end

   // Shared MAC operand select, product and saturated output code.
   always_comb begin
      pcm_sel_s  = pcm_snap_q[ch_q*DW +: DW];
      vol_sel_s  = vol_snap_q[ch_q*VOLW +: VOLW];
      lvl_sel_s  = lvl_snap_q[ch_q*ENVW +: ENVW];
      samp_s     = DW'(offset_to_signed(64'(pcm_sel_s), DW));
      prod_s     = ACCW'(samp_s)
                 * ACCW'($signed({1'b0, vol_sel_s}))
                 * ACCW'($signed({1'b0, lvl_sel_s}));
      shift_s    = acc_q >>> SHIFT;
      clip_s     = DW'(sat_signed(64'(shift_s), DW));
      out_code_s = DW'(signed_to_offset(64'(clip_s), DW));
   end

   // Mix sequencer: snapshot on strobe, accumulate one voice per clock, then emit.
   always_comb begin
      mix_d       = mix_q;
      ch_d        = ch_q;
      acc_d       = acc_q;
      pcm_snap_d  = pcm_snap_q;
      vol_snap_d  = vol_snap_q;
      lvl_snap_d  = lvl_snap_q;
      pcm_out_d   = pcm_out_q;
      out_valid_d = 1'b0;
      busy_d      = busy_q;
      overrun_d   = 1'b0;
      case (mix_q)
         MIX_IDLE: begin
            if (sample_stb) begin
               pcm_snap_d = pcm_in;
               vol_snap_d = vol;
               lvl_snap_d = lvl_s;
               ch_d       = {CW{1'b0}};
               acc_d      = {ACCW{1'b0}};
               busy_d     = 1'b1;
               mix_d      = MIX_ACC;
            end else begin
               mix_d = MIX_IDLE;
            end
         end
         MIX_ACC: begin
            overrun_d = sample_stb;
            acc_d     = acc_q + prod_s;
            if (ch_q == CH_LAST) begin
               mix_d = MIX_OUT;
            end else begin
               ch_d = ch_q + CW'(1);
            end
         end
         MIX_OUT: begin
            overrun_d   = sample_stb;
            pcm_out_d   = out_code_s;
            out_valid_d = 1'b1;
            busy_d      = 1'b0;
            mix_d       = MIX_IDLE;
         end
         default: begin
            busy_d = 1'b0;
            mix_d  = MIX_IDLE;
         end
      endcase
   end

   // Mix sequencer, snapshot and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mix_q       <= MIX_IDLE;
         ch_q        <= {CW{1'b0}};
         acc_q       <= {ACCW{1'b0}};
         pcm_snap_q  <= {(NCH*DW){1'b0}};
         vol_snap_q  <= {(NCH*VOLW){1'b0}};
         lvl_snap_q  <= {(NCH*ENVW){1'b0}};
         pcm_out_q   <= PCM_MID_C;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         mix_q       <= mix_d;
         ch_q        <= ch_d;
         acc_q       <= acc_d;
         pcm_snap_q  <= pcm_snap_d;
         vol_snap_q  <= vol_snap_d;
         lvl_snap_q  <= lvl_snap_d;
         pcm_out_q   <= pcm_out_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         overrun_q   <= overrun_d;
      end
   end

   assign pcm_out   = pcm_out_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_voice_mixer.sv
// tb_voice_mixer: directed vectors with hand-computed expectations for voice_mixer.
module tb_voice_mixer;

   localparam int NCH     = 4;
   localparam int DW      = 16;
   localparam int VOLW    = 4;
   localparam int ENVW    = 8;
   localparam int ENV_DIV = 4;

   logic                clk;
   logic                rst_n;
   logic                sample_stb;
   logic [NCH*DW-1:0]   pcm_in;
   logic [NCH*VOLW-1:0] vol;
   logic [NCH-1:0]      gate;
   logic [ENVW-1:0]     attack_step;
   logic [ENVW-1:0]     release_step;
   logic [DW-1:0]       pcm_out;
   logic                out_valid;
   logic                busy;
   logic                overrun;
   logic [NCH-1:0]      env_active;

   int check_cnt = 0;
   int err_cnt   = 0;

   voice_mixer #(
      .NCH     (NCH),
      .DW      (DW),
      .VOLW    (VOLW),
      .ENVW    (ENVW),
      .ENV_DIV (ENV_DIV)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_stb   (sample_stb),
      .pcm_in       (pcm_in),
      .vol          (vol),
      .gate         (gate),
      .attack_step  (attack_step),
      .release_step (release_step),
      .pcm_out      (pcm_out),
      .out_valid    (out_valid),
      .busy         (busy),
      .overrun      (overrun),
      .env_active   (env_active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      check_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One strobe; expects busy right after S0, out_valid 5 edges later with the given code.
   task automatic mix_once(input string tag, input logic [DW-1:0] exp);
      int            lat;
      logic [DW-1:0] res;
      lat = 0;
      res = 16'h0000;
      @(negedge clk); sample_stb = 1'b1;
      @(posedge clk); #1;
      check_val({tag, "_busy"}, 64'(busy), 64'd1);
      @(negedge clk); sample_stb = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (out_valid) begin
            lat = k;
            res = pcm_out;
            break;
         end
      end
      check_val({tag, "_lat"}, 64'(lat), 64'd5);
      check_val({tag, "_pcm"}, 64'(res), 64'(exp));
   endtask

   // Wait (bounded) for voice 0 level to change, then check the new level and tick spacing.
   task automatic wait_lvl(input string tag, input logic [7:0] exp, input int exp_dt);
      logic [7:0] prev;
      int         dt;
      prev = dut.lvl_s[7:0];
      dt   = 0;
      while ((dut.lvl_s[7:0] == prev) && (dt < 40)) begin
         @(negedge clk);
         dt++;
      end
      check_val(tag, 64'(dut.lvl_s[7:0]), 64'(exp));
      if (exp_dt > 0) begin
         check_val({tag, "_dt"}, 64'(dt), 64'(exp_dt));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int ov_cnt;
      int first_edge;
      logic [DW-1:0] first_val;

      rst_n        = 1'b1;
      sample_stb   = 1'b0;
      pcm_in       = {NCH{16'h8000}};
      vol          = 16'h0000;
      gate         = 4'b0000;
      attack_step  = 8'd0;
      release_step = 8'd0;

      // Reset state
      #2 rst_n = 1'b0;
      #10;
      check_val("rst_pcm",   64'(pcm_out),    64'h8000);
      check_val("rst_valid", 64'(out_valid),  64'd0);
      check_val("rst_busy",  64'(busy),       64'd0);
      check_val("rst_ovr",   64'(overrun),    64'd0);
      check_val("rst_env",   64'(env_active), 64'd0);
      @(negedge clk); rst_n = 1'b1;

      // Single voice at full volume and envelope: 16384*15*255 >>> 12 = 15300 -> 0xBBC4
      pcm_in = {16'h8000, 16'h8000, 16'h8000, 16'hC000};
      vol    = 16'hFFFF;
      gate   = 4'b0001;
      repeat (4) @(negedge clk);
      check_val("single_env", 64'(env_active), 64'h1);
      mix_once("single", 16'hBBC4);

      // Saturation in both directions
      gate = 4'b1111;
      repeat (4) @(negedge clk);
      check_val("all_env", 64'(env_active), 64'hF);
      pcm_in = {NCH{16'hFFFF}};
      mix_once("sat_hi", 16'hFFFF);
      pcm_in = {NCH{16'h0000}};
      mix_once("sat_lo", 16'h0000);

      // Mixed signs: ch0 +16384*15*255, ch1 -16384*5*255 -> 10200 -> 0xA7D8
      pcm_in = {16'h8000, 16'h8000, 16'h4000, 16'hC000};
      vol    = 16'h005F;
      mix_once("mixed", 16'hA7D8);

      // Floor shift: -1*1*255 >>> 12 = -1 -> 0x7FFF
      pcm_in = {16'h8000, 16'h8000, 16'h8000, 16'h7FFF};
      vol    = 16'h0001;
      mix_once("floor", 16'h7FFF);

      // Overrun: second strobe at edge 2; result comes from the first snapshot
      pcm_in = {16'h8000, 16'h8000, 16'h8000, 16'hC000};
      vol    = 16'hFFFF;
      @(negedge clk); sample_stb = 1'b1;
      @(posedge clk); #1;
      @(negedge clk); sample_stb = 1'b0; pcm_in = {NCH{16'hFFFF}};
      @(posedge clk); #1;
      @(negedge clk); sample_stb = 1'b1;
      @(posedge clk); #1;
      check_val("ovr_pulse", 64'(overrun), 64'd1);
      @(negedge clk); sample_stb = 1'b0;
      @(posedge clk); #1;
      check_val("ovr_clear", 64'(overrun), 64'd0);
      ov_cnt     = 0;
      first_edge = 0;
      first_val  = 16'h0000;
      for (int e = 4; e <= 16; e++) begin
         @(posedge clk); #1;
         if (out_valid) begin
            ov_cnt++;
            if (first_edge == 0) begin
               first_edge = e;
               first_val  = pcm_out;
            end
         end
      end
      check_val("ovr_count", 64'(ov_cnt),     64'd1);
      check_val("ovr_lat",   64'(first_edge), 64'd5);
      check_val("ovr_pcm",   64'(first_val),  64'hBBC4);

      // Async reset at edge 2 of accumulation
      @(negedge clk); sample_stb = 1'b1;
      @(posedge clk); #1;
      @(negedge clk); sample_stb = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      gate = 4'b0000;
      #1;
      check_val("arst_pcm",   64'(pcm_out),    64'h8000);
      check_val("arst_busy",  64'(busy),       64'd0);
      check_val("arst_valid", 64'(out_valid),  64'd0);
      check_val("arst_env",   64'(env_active), 64'd0);
      @(negedge clk); rst_n = 1'b1;
      ov_cnt = 0;
      for (int e = 0; e < 12; e++) begin
         @(posedge clk); #1;
         if (out_valid) ov_cnt++;
      end
      check_val("arst_no_valid", 64'(ov_cnt), 64'd0);

      // Envelope: attack 64/tick, release 100/tick, tick every 4 clocks
      attack_step  = 8'd64;
      release_step = 8'd100;
      @(negedge clk); gate = 4'b0001;
      wait_lvl("att1", 8'd64,  0);
      wait_lvl("att2", 8'd128, 4);
      wait_lvl("att3", 8'd192, 4);
      wait_lvl("att4", 8'd255, 4);
      check_val("att_env", 64'(env_active), 64'h1);
      repeat (8) @(negedge clk);
      check_val("sustain", 64'(dut.lvl_s[7:0]), 64'd255);
      gate = 4'b0000;
      wait_lvl("rel1", 8'd155, 0);
      gate = 4'b0001;
      wait_lvl("regate1", 8'd219, 4);
      wait_lvl("regate2", 8'd255, 4);
      gate = 4'b0000;
      wait_lvl("rel_a", 8'd155, 0);
      wait_lvl("rel_b", 8'd55,  4);
      check_val("rel_env", 64'(env_active), 64'h1);
      wait_lvl("rel_c", 8'd0,   4);
      check_val("idle_env", 64'(env_active), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
      $finish;
   end

endmodule
